sample_frame_collector: RTL and testbench

SAMPLE_FRAME_COLLECTOR -- requirements
Module: sample_frame_collector

---
 rtl/sample_frame_collector.sv | 168 ++++++++++++++++
 tb/tb_sample_frame_collector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_frame_collector.sv
// Collects NUM_INPUT signed samples into a frame and hands it to a single-entry output bank.
// Optional macro SAMPLE_FRAME_COLLECTOR_ZERO_PAD_EN zero-pads early-terminated frames instead of dropping them.
module sample_frame_collector #(
    parameter int NUM_INPUT = 2,
    parameter int WIDTH_IN  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [WIDTH_IN-1:0] in_data,
    input  logic                       in_last,
    output logic signed [WIDTH_IN-1:0] out_data [NUM_INPUT],
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       frame_drop
);

    localparam int CW = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_INPUT - 1);

    if (WIDTH_IN <= 0) begin : g_bad_width
        $error("sample_frame_collector: WIDTH_IN must be positive");
    end
    if (NUM_INPUT < 2) begin : g_bad_num
        $error("sample_frame_collector: NUM_INPUT must be at least 2");
    end

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t                     state_r;
    state_t                     state_next_s;
    logic [CW-1:0]              fill_cnt_r;
    logic signed [WIDTH_IN-1:0] coll_r    [NUM_INPUT];
    logic signed [WIDTH_IN-1:0] out_bank_r [NUM_INPUT];
    logic signed [WIDTH_IN-1:0] frame_s   [NUM_INPUT];
    logic                       out_valid_r;
    logic                       frame_drop_r;
    logic                       accept_s;
    logic                       at_last_s;
    logic                       complete_s;
    logic                       early_drop_s;
    logic                       bank_free_s;
    logic                       load_frame_s;
    logic                       load_pend_s;
    logic                       park_s;
    logic                       drop_s;
    logic                       write_s;

    assign in_ready    = (state_r == COLLECT) & ~rst;
    assign accept_s    = in_valid & in_ready;
    assign at_last_s   = (fill_cnt_r == LAST_SLOT);
    assign bank_free_s = ~out_valid_r | out_ready;
    assign out_valid   = out_valid_r;
    assign frame_drop  = frame_drop_r;
    assign out_data    = out_bank_r;

`ifdef SAMPLE_FRAME_COLLECTOR_ZERO_PAD_EN
    assign complete_s   = at_last_s | in_last;
    assign early_drop_s = 1'b0;
`else
    assign complete_s   = at_last_s;
    assign early_drop_s = in_last & ~at_last_s;
`endif

    // Frame as it would look with the current sample merged at fill_cnt (unfilled slots padded when enabled)
    always_comb begin
        for (int i = 0; i < NUM_INPUT; i++) begin
            if (CW'(i) < fill_cnt_r) begin
                frame_s[i] = coll_r[i];
            end else if (CW'(i) == fill_cnt_r) begin
                frame_s[i] = in_data;
            end else begin
`ifdef SAMPLE_FRAME_COLLECTOR_ZERO_PAD_EN
                frame_s[i] = '0;
`else
                frame_s[i] = coll_r[i];
`endif
            end
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_next_s = state_r;
        load_frame_s = 1'b0;
        load_pend_s  = 1'b0;
        park_s       = 1'b0;
        drop_s       = 1'b0;
        write_s      = 1'b0;
        case (state_r)
            COLLECT: begin
                if (accept_s) begin
                    if (complete_s) begin
                        if (bank_free_s) begin
                            load_frame_s = 1'b1;
                        end else begin
                            park_s       = 1'b1;
                            state_next_s = PENDING;
                        end
                    end else if (early_drop_s) begin
                        drop_s = 1'b1;
                    end else begin
                        write_s = 1'b1;
                    end
                end else begin
                    state_next_s = COLLECT;
                end
            end
            PENDING: begin
                if (out_ready) begin
                    load_pend_s  = 1'b1;
                    state_next_s = COLLECT;
                end else begin
                    state_next_s = PENDING;
                end
            end
            default: begin
                state_next_s = COLLECT;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= COLLECT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Collection bank, fill counter and output bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt_r   <= '0;
            out_valid_r  <= 1'b0;
            frame_drop_r <= 1'b0;
            for (int i = 0; i < NUM_INPUT; i++) begin
                coll_r[i]     <= '0;
                out_bank_r[i] <= '0;
            end
        end else begin
            frame_drop_r <= drop_s;
            if (load_frame_s || load_pend_s) begin
                out_valid_r <= 1'b1;
                for (int i = 0; i < NUM_INPUT; i++) begin
                    out_bank_r[i] <= load_frame_s ? frame_s[i] : coll_r[i];
                end
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
            if (write_s) begin
                coll_r[fill_cnt_r] <= in_data;
                fill_cnt_r         <= fill_cnt_r + CW'(1);
            end else if (park_s) begin
                coll_r     <= frame_s;
                fill_cnt_r <= '0;
            end else if (load_frame_s || load_pend_s || drop_s) begin
                fill_cnt_r <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sample_frame_collector.sv
// Self-checking bench for sample_frame_collector (NUM_INPUT=4, WIDTH_IN=8): vector table,
// directed corner sequences and randomized traffic against a queue-based frame model.
module tb_sample_frame_collector;

    localparam int N = 4;
    localparam int W = 8;
`ifdef SAMPLE_FRAME_COLLECTOR_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] in_data = '0;
    logic                in_last = 1'b0;
    logic signed [W-1:0] out_data [N];
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                frame_drop;

    int tests = 0;
    int fails = 0;

    // Reference model: partial frame as a queue, one parked frame, one output frame
    byte cur[$];
    byte pend [N];
    bit  pend_full;
    byte mout [N];
    bit  mov;
    bit  mdrop;

    sample_frame_collector #(.NUM_INPUT(N), .WIDTH_IN(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .frame_drop(frame_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cur.delete();
        pend_full = 1'b0;
        mov = 1'b0;
        mdrop = 1'b0;
        for (int i = 0; i < N; i++) begin
            mout[i] = 8'sd0;
            pend[i] = 8'sd0;
        end
    endtask

    task automatic model_step(input bit v, input int d, input bit l, input bit ordy);
        bit  acc;
        bit  free;
        bit  loaded;
        byte frame [N];
        acc = v && !pend_full;
        free = !mov || ordy;
        loaded = 1'b0;
        mdrop = 1'b0;
        if (pend_full) begin
            if (ordy) begin
                mout = pend;
                mov = 1'b1;
                loaded = 1'b1;
                pend_full = 1'b0;
            end
        end else if (acc) begin
            cur.push_back(byte'(d));
            if (cur.size() == N || (PAD && l)) begin
                for (int i = 0; i < N; i++) frame[i] = (i < cur.size()) ? cur[i] : 8'sd0;
                cur.delete();
                if (free) begin
                    mout = frame;
                    mov = 1'b1;
                    loaded = 1'b1;
                end else begin
                    pend = frame;
                    pend_full = 1'b1;
                end
            end else if (l) begin
                cur.delete();
                mdrop = 1'b1;
            end
        end
        if (!loaded && ordy) mov = 1'b0;
    endtask

    task automatic check_outputs();
        chk("out_valid", int'(out_valid), int'(mov));
        chk("frame_drop", int'(frame_drop), int'(mdrop));
        for (int i = 0; i < N; i++) chk($sformatf("out_data[%0d]", i), int'(out_data[i]), int'(mout[i]));
    endtask

    // One clock cycle: drive at negedge, check ready, step model at posedge, check outputs after
    task automatic cyc(input bit v, input int d, input bit l, input bit ordy);
        @(negedge clk);
        in_valid = v;
        in_data = W'(d);
        in_last = l;
        out_ready = ordy;
        #1;
        chk("in_ready", int'(in_ready), int'(!pend_full));
        @(posedge clk);
        model_step(v, d, l, ordy);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst in_ready", int'(in_ready), 0);
        check_outputs();
        @(negedge clk);
        chk("rst held in_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("post-rst in_ready", int'(in_ready), 1);
    endtask

    typedef struct {
        bit v; int d; bit l; bit r;
        bit eov; int e0; int e1; int e2; int e3;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{1'b1, 1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0};
        tbl[1] = '{1'b1, 2, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0};
        tbl[2] = '{1'b1, 3, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0};
        tbl[3] = '{1'b1, 4, 1'b0, 1'b1, 1'b1, 1, 2, 3, 4};
        tbl[4] = '{1'b0, 9, 1'b1, 1'b1, 1'b0, 1, 2, 3, 4};
        tbl[5] = '{1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 2, 3, 4};

        model_reset();
        do_reset();

        // Basic frame from the vector table
        for (int k = 0; k < 6; k++) begin
            cyc(tbl[k].v, tbl[k].d, tbl[k].l, tbl[k].r);
            chk($sformatf("tbl%0d ov", k), int'(out_valid), int'(tbl[k].eov));
            chk($sformatf("tbl%0d d0", k), int'(out_data[0]), tbl[k].e0);
            chk($sformatf("tbl%0d d1", k), int'(out_data[1]), tbl[k].e1);
            chk($sformatf("tbl%0d d2", k), int'(out_data[2]), tbl[k].e2);
            chk($sformatf("tbl%0d d3", k), int'(out_data[3]), tbl[k].e3);
        end

        // Streaming 10..21 with out_ready held high
        for (int k = 0; k < 12; k++) begin
            cyc(1'b1, 10 + k, 1'b0, 1'b1);
            if (k % 4 == 3) begin
                chk("stream ov", int'(out_valid), 1);
                chk("stream d0", int'(out_data[0]), 7 + k);
                chk("stream d3", int'(out_data[3]), 10 + k);
            end
        end
        cyc(1'b0, 0, 1'b0, 1'b1);

        // Backpressure: 8 samples offered with out_ready low for 10 cycles
        for (int k = 0; k < 10; k++) cyc(k < 8, 30 + k, 1'b0, 1'b0);
        chk("bp held d0", int'(out_data[0]), 30);
        chk("bp held ov", int'(out_valid), 1);
        @(negedge clk);
        #1;
        chk("bp in_ready low", int'(in_ready), 0);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("bp second d0", int'(out_data[0]), 34);
        chk("bp second d3", int'(out_data[3]), 37);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("bp ready back", int'(in_ready), 1);

        // Signed extremes
        cyc(1'b1, -128, 1'b0, 1'b1);
        cyc(1'b1, 127, 1'b0, 1'b1);
        cyc(1'b1, -1, 1'b0, 1'b1);
        cyc(1'b1, 0, 1'b0, 1'b1);
        chk("ext d0", int'(out_data[0]), -128);
        chk("ext d1", int'(out_data[1]), 127);
        chk("ext d2", int'(out_data[2]), -1);
        chk("ext d3", int'(out_data[3]), 0);
        cyc(1'b0, 0, 1'b0, 1'b1);

        // Early last after two samples
        cyc(1'b1, 5, 1'b0, 1'b1);
        cyc(1'b1, 6, 1'b1, 1'b1);
`ifdef SAMPLE_FRAME_COLLECTOR_ZERO_PAD_EN
        chk("pad ov", int'(out_valid), 1);
        chk("pad d0", int'(out_data[0]), 5);
        chk("pad d1", int'(out_data[1]), 6);
        chk("pad d2", int'(out_data[2]), 0);
        chk("pad d3", int'(out_data[3]), 0);
        cyc(1'b0, 0, 1'b0, 1'b1);
`else
        chk("drop pulse", int'(frame_drop), 1);
        chk("drop ov", int'(out_valid), 0);
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("drop one cycle", int'(frame_drop), 0);
        for (int k = 0; k < 4; k++) cyc(1'b1, 40 + k, 1'b0, 1'b1);
        chk("after drop d0", int'(out_data[0]), 40);
        chk("after drop d3", int'(out_data[3]), 43);
`endif

        // Reset mid-frame, then a fresh frame starts at slot 0
        cyc(1'b1, 50, 1'b0, 1'b1);
        cyc(1'b1, 51, 1'b0, 1'b1);
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1'b1, 60 + k, 1'b0, 1'b1);
        chk("rst-mid d0", int'(out_data[0]), 60);

        // Reset while PENDING
        for (int k = 0; k < 8; k++) cyc(1'b1, 70 + k, 1'b0, 1'b0);
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1'b1, 80 + k, 1'b0, 1'b1);
        chk("rst-pend d0", int'(out_data[0]), 80);
        chk("rst-pend d3", int'(out_data[3]), 83);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
